// File: rtl/cache_ctrl_fsm.sv
// Miss-handling controller for a direct-mapped cache: lookup, dirty write-back, banked refill, replay.
// Optional saturating hit/miss counters are compiled in when CACHE_CTRL_PERF_EN is defined.
module cache_ctrl_fsm #(
   parameter int WORDS = 4
`ifdef CACHE_CTRL_PERF_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_rd,
   input  logic                     req_wr,
   output logic                     busy,
   output logic                     done,
   output logic                     hit_out,
   output logic                     err,
   output logic                     cache_en,
   output logic                     cache_comp,
   output logic                     cache_write,
   output logic                     cache_vld_in,
   output logic                     off_ovr,
   output logic [$clog2(WORDS)-1:0] cache_off,
   input  logic                     cache_hit,
   input  logic                     cache_valid,
   input  logic                     cache_dirty,
   output logic                     mem_rd,
   output logic                     mem_wr,
   output logic                     mem_tag_sel,
   output logic [$clog2(WORDS)-1:0] mem_off,
   input  logic                     mem_stall,
   input  logic                     mem_rvalid
`ifdef CACHE_CTRL_PERF_EN
   , output logic [CNT_W-1:0]       hit_cnt
   , output logic [CNT_W-1:0]       miss_cnt
`endif
);

   localparam int OFFW = $clog2(WORDS);
   localparam logic [OFFW:0] CNT_FULL = WORDS[OFFW:0];
   localparam logic [OFFW:0] CNT_LAST = CNT_FULL - 1'b1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_WB     = 3'd2,
      S_ALLOC  = 3'd3,
      S_REPLAY = 3'd4
   } state_t;

   state_t          state;
   logic [OFFW:0]   iss_cnt;
   logic [OFFW:0]   fil_cnt;
   logic            op_wr;
   logic            issuing;

   assign issuing = (state == S_ALLOC) && (iss_cnt < CNT_FULL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         iss_cnt <= '0;
         fil_cnt <= '0;
         op_wr   <= 1'b0;
         err     <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_rd && req_wr) begin
                  err <= 1'b1;
               end else if (req_rd || req_wr) begin
                  op_wr <= req_wr;
                  state <= S_LOOKUP;
               end
               if (mem_rvalid) err <= 1'b1;
            end
            S_LOOKUP: begin
               iss_cnt <= '0;
               fil_cnt <= '0;
               if (cache_hit && cache_valid)        state <= S_IDLE;
               else if (cache_valid && cache_dirty) state <= S_WB;
               else                                 state <= S_ALLOC;
            end
            S_WB: begin
               if (!mem_stall) begin
                  if (iss_cnt == CNT_LAST) begin
                     iss_cnt <= '0;
                     state   <= S_ALLOC;
                  end else begin
                     iss_cnt <= iss_cnt + 1'b1;
                  end
               end
            end
            S_ALLOC: begin
               if (issuing && !mem_stall) iss_cnt <= iss_cnt + 1'b1;
               // issue and fill progress independently; the fill count alone ends the refill
               if (mem_rvalid) begin
                  if (fil_cnt == CNT_FULL) begin
                     err <= 1'b1;
                  end else begin
                     fil_cnt <= fil_cnt + 1'b1;
                     if (fil_cnt == CNT_LAST) state <= S_REPLAY;
                  end
               end
            end
            S_REPLAY: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // Strobes depend on same-cycle cache/memory responses, so they are decoded, not registered.
   always_comb begin
      busy         = (state != S_IDLE);
      done         = 1'b0;
      hit_out      = 1'b0;
      cache_en     = 1'b0;
      cache_comp   = 1'b0;
      cache_write  = 1'b0;
      cache_vld_in = 1'b0;
      off_ovr      = 1'b0;
      cache_off    = '0;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      mem_tag_sel  = 1'b0;
      mem_off      = '0;
      case (state)
         S_LOOKUP: begin
            cache_en    = 1'b1;
            cache_comp  = 1'b1;
            cache_write = op_wr;
            if (cache_hit && cache_valid) begin
               done    = 1'b1;
               hit_out = 1'b1;
            end
         end
         S_WB: begin
            off_ovr     = 1'b1;
            cache_en    = 1'b1;
            cache_off   = iss_cnt[OFFW-1:0];
            mem_off     = iss_cnt[OFFW-1:0];
            mem_wr      = 1'b1;
            mem_tag_sel = 1'b1;
         end
         S_ALLOC: begin
            if (issuing) begin
               mem_rd  = 1'b1;
               mem_off = iss_cnt[OFFW-1:0];
            end
            if (mem_rvalid) begin
               cache_en     = 1'b1;
               cache_write  = 1'b1;
               cache_vld_in = 1'b1;
               off_ovr      = 1'b1;
               cache_off    = fil_cnt[OFFW-1:0];
            end
         end
         S_REPLAY: begin
            cache_en    = 1'b1;
            cache_comp  = 1'b1;
            cache_write = op_wr;
            done        = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef CACHE_CTRL_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (done) begin
         if (hit_out) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
         end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
         end
      end
   end
`endif

endmodule
